seq_divider: RTL and testbench

- Sequential restoring divider. It is the inverse counterpart of the team's sequential shift-add multiplier.
- Computes an unsigned WIDTH-bit quotient and remainder, producing one quotient bit per clock.
- Built from an iteration counter, a partial-remainder register and a shifting quotient register, sequenced by a small FSM.
- Sits beside the multiplier in the datapath and uses the same start/busy/done handshake style.

---
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider.sv | 123 ++++++++++++
 tb/tb_seq_divider.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake and operand/result bus of the
// sequential divider.
//   master : requester, drives start, dividend and divisor; reads results
//   slave  : divider, receives operands; drives busy, done, quotient,
//            remainder and div_by_zero
interface seq_divider_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: unsigned sequential restoring divider, one quotient bit per
// clock. Companion of the shift-add multiplier, same start/busy/done style.
// Ports:
//   clk     : clock, all state changes on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : seq_divider_if.slave (start, dividend, divisor in;
//             busy, done, quotient, remainder, div_by_zero out)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; result outputs hold the last result
// S_RUN  | one restoring step per clock, WIDTH steps in total
// S_DONE | one-cycle done pulse; start ignored, back to S_IDLE
module seq_divider #(
   parameter int WIDTH = 4
) (
   input logic         clk,
   input logic         reset_n,
   seq_divider_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   prem;
   logic [WIDTH-1:0] qsr;
   logic [WIDTH-1:0] dvsr;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;

   logic [2*WIDTH:0] pair_shl;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   prem_nxt;
   logic [WIDTH-1:0] qsr_nxt;

   // One restoring step: shift {prem, qsr} left, try subtracting the divisor
   // and keep the difference only if it did not borrow (trial MSB clear).
   always_comb begin
      pair_shl = {prem, qsr} << 1;
      shifted  = pair_shl[2*WIDTH:WIDTH];
      trial    = shifted - {1'b0, dvsr};
      prem_nxt = trial[WIDTH] ? shifted : trial;
      qsr_nxt  = pair_shl[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         prem        <= '0;
         qsr         <= '0;
         dvsr        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  qsr  <= bus.dividend;
                  dvsr <= bus.divisor;
                  prem <= '0;
                  cnt  <= CW'(WIDTH);
                  if (bus.divisor != '0) begin
                     state  <= S_RUN;
                     busy_q <= 1'b1;
                  end else begin
                     // Divide by zero resolves immediately, no RUN phase.
                     state       <= S_DONE;
                     done_q      <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= bus.dividend;
                     dbz_q       <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               prem <= prem_nxt;
               qsr  <= qsr_nxt;
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state       <= S_DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  quotient_q  <= qsr_nxt;
                  remainder_q <= prem_nxt[WIDTH-1:0];
                  dbz_q       <= 1'b0;
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               done_q <= 1'b0;
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider at WIDTH=4 and WIDTH=8.
module tb_seq_divider;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   seq_divider_if #(.WIDTH(4)) i4 ();
   seq_divider_if #(.WIDTH(8)) i8 ();

   seq_divider #(.WIDTH(4)) u_div4 (.clk(clk), .reset_n(reset_n), .bus(i4.slave));
   seq_divider #(.WIDTH(8)) u_div8 (.clk(clk), .reset_n(reset_n), .bus(i8.slave));

   int total = 0;
   int bad   = 0;

   int last_q4 = 0;
   int last_r4 = 0;

   typedef struct {
      int dd;
      int dvs;
      int q;
      int r;
      bit dz;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer division; divide by zero gives all-ones
   // quotient and the dividend as remainder.
   function automatic void ref_div(input int w, input int dd, input int dvs,
                                   output int q, output int r, output bit dz);
      if (dvs == 0) begin
         q  = (1 << w) - 1;
         r  = dd;
         dz = 1'b1;
      end else begin
         q  = dd / dvs;
         r  = dd % dvs;
         dz = 1'b0;
      end
   endfunction

   // Full handshake on the WIDTH=4 unit with cycle-exact timing checks.
   task automatic run4(input int dd, input int dvs, input int eq, input int er, input bit edz);
      @(negedge clk);
      i4.start    = 1'b1;
      i4.dividend = dd[3:0];
      i4.divisor  = dvs[3:0];
      @(negedge clk);
      i4.start = 1'b0;
      if (dvs != 0) begin
         for (int k = 0; k < 4; k++) begin
            check("run_busy", i4.busy, 1);
            check("run_done", i4.done, 0);
            check("run_q_hold", i4.quotient, last_q4);
            check("run_r_hold", i4.remainder, last_r4);
            @(negedge clk);
         end
      end
      check("fin_done", i4.done, 1);
      check("fin_busy", i4.busy, 0);
      check("fin_q", i4.quotient, eq);
      check("fin_r", i4.remainder, er);
      check("fin_dz", i4.div_by_zero, edz);
      last_q4 = eq;
      last_r4 = er;
      @(negedge clk);
      check("post_done", i4.done, 0);
      check("post_q_hold", i4.quotient, eq);
      check("post_r_hold", i4.remainder, er);
   endtask

   task automatic run8(input int dd, input int dvs);
      int eq, er, k;
      bit edz;
      ref_div(8, dd, dvs, eq, er, edz);
      @(negedge clk);
      i8.start    = 1'b1;
      i8.dividend = dd[7:0];
      i8.divisor  = dvs[7:0];
      @(negedge clk);
      i8.start = 1'b0;
      k = 0;
      while (!i8.done && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("w8_done", i8.done, 1);
      check("w8_latency", k, edz ? 0 : 8);
      check("w8_q", i8.quotient, eq);
      check("w8_r", i8.remainder, er);
      check("w8_dz", i8.div_by_zero, edz);
      @(negedge clk);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int eq, er;
      bit edz;

      vecs[0] = '{13, 3, 4, 1, 1'b0};
      vecs[1] = '{15, 1, 15, 0, 1'b0};
      vecs[2] = '{5, 7, 0, 5, 1'b0};
      vecs[3] = '{0, 9, 0, 0, 1'b0};
      vecs[4] = '{9, 0, 15, 9, 1'b1};
      vecs[5] = '{8, 2, 4, 0, 1'b0};

      reset_n     = 1'b0;
      i4.start    = 1'b0;
      i4.dividend = '0;
      i4.divisor  = '0;
      i8.start    = 1'b0;
      i8.dividend = '0;
      i8.divisor  = '0;

      #12;
      check("rst_busy", i4.busy, 0);
      check("rst_done", i4.done, 0);
      check("rst_q", i4.quotient, 0);
      check("rst_r", i4.remainder, 0);
      check("rst_dz", i4.div_by_zero, 0);
      check("rst8_q", i8.quotient, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed table
      foreach (vecs[i])
         run4(vecs[i].dd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dz);

      // start pulsed mid-RUN with new operands, operands changed again
      @(negedge clk);
      i4.start    = 1'b1;
      i4.dividend = 4'd14;
      i4.divisor  = 4'd4;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            i4.start    = 1'b0;
            i4.dividend = 4'd0;
            i4.divisor  = 4'd0;
         end else if (i == 1) begin
            i4.start    = 1'b1;
            i4.dividend = 4'd7;
            i4.divisor  = 4'd7;
         end else if (i == 2) begin
            i4.start    = 1'b0;
            i4.dividend = 4'd1;
            i4.divisor  = 4'd1;
         end
         check("ign_done", i4.done, (i == 4) ? 1 : 0);
      end
      check("ign_q", i4.quotient, 3);
      check("ign_r", i4.remainder, 2);
      check("ign_dz", i4.div_by_zero, 0);

      // start held high: one acceptance every WIDTH+2 cycles
      i4.start    = 1'b1;
      i4.dividend = 4'd6;
      i4.divisor  = 4'd3;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         check("hold_done", i4.done, (i % 6 == 4) ? 1 : 0);
      end
      i4.start = 1'b0;
      check("hold_q", i4.quotient, 2);
      check("hold_r", i4.remainder, 0);
      last_q4 = 2;
      last_r4 = 0;
      @(negedge clk);

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      i4.start    = 1'b1;
      i4.dividend = 4'd11;
      i4.divisor  = 4'd2;
      @(negedge clk);
      i4.start = 1'b0;
      @(negedge clk);
      check("mid_busy", i4.busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_busy", i4.busy, 0);
      check("arst_done", i4.done, 0);
      check("arst_q", i4.quotient, 0);
      check("arst_r", i4.remainder, 0);
      check("arst_dz", i4.div_by_zero, 0);
      @(negedge clk);
      reset_n = 1'b1;
      last_q4 = 0;
      last_r4 = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("idle_done", i4.done, 0);
         check("idle_busy", i4.busy, 0);
      end
      run4(11, 2, 5, 1, 1'b0);

      // Exhaustive WIDTH=4 sweep against the reference
      for (int dd = 0; dd < 16; dd++) begin
         for (int dvs = 0; dvs < 16; dvs++) begin
            ref_div(4, dd, dvs, eq, er, edz);
            run4(dd, dvs, eq, er, edz);
         end
      end

      // WIDTH=8: boundary case, then random pairs
      run8(255, 16);
      check("w8_255_16_q", i8.quotient, 15);
      check("w8_255_16_r", i8.remainder, 15);
      run8(200, 0);
      for (int n = 0; n < 200; n++)
         run8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
